hazard_sched: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Drives PC write-enable, IF/ID write and flush, and the ID/EX flush input.
- Inserts load-use bubbles and squashes wrong-path instructions on taken branches and jumps.
- Stalls the front end while the multi-cycle multiply/divide unit (MDU) runs, and sequences interrupt entry.

---
 rtl/hazard_sched.sv | 143 ++++++++++++++
 tb/tb_hazard_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// It handles load-use bubbles, branch/jump squash, MDU front-end stalls and interrupt entry.
module hazard_sched #(
  parameter int unsigned MDU_TIMEOUT = 40,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic       id_mdu_op,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       mdu_done,
  input  logic       irq,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       mdu_start,
  output logic       irq_ack,
  output logic       mdu_timeout,
  output logic       busy
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MDU_WAIT  = 2'd1,
    IRQ_ENTER = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_pend_q, irq_pend_d;
  logic             mdu_timeout_q, mdu_timeout_d;

  logic pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c, mdu_start_c, irq_ack_c;
  logic irq_take, load_use, mdu_release;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign mdu_release = mdu_done || (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      irq_pend_q    <= 1'b0;
      mdu_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      irq_pend_q    <= irq_pend_d;
      mdu_timeout_q <= mdu_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    irq_pend_d    = irq_pend_q;
    mdu_timeout_d = mdu_timeout_q;
    pc_write_c    = 1'b0;
    ifid_write_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    mdu_start_c   = 1'b0;
    irq_ack_c     = 1'b0;
    irq_take      = 1'b0;

    unique case (state_q)
      RUN: begin
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        cnt_d        = '0;
        if (ex_branch_taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (load_use) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          idex_flush_c = 1'b1;
        end else if (id_jump) begin
          ifid_flush_c = 1'b1;
        end else if (irq || irq_pend_q) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          irq_take     = 1'b1;
          state_d      = IRQ_ENTER;
        end else if (id_mdu_op) begin
          mdu_start_c  = 1'b1;
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          idex_flush_c = 1'b1;
          state_d      = MDU_WAIT;
        end
        // A request shadowed by a higher-priority event is remembered for later.
        if (irq && !irq_take) irq_pend_d = 1'b1;
      end

      MDU_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (irq) irq_pend_d = 1'b1;
        if (mdu_release) begin
          pc_write_c   = 1'b1;
          ifid_write_c = 1'b1;
          state_d      = RUN;
          if (!mdu_done) mdu_timeout_d = 1'b1;
        end else begin
          idex_flush_c = 1'b1;
        end
      end

      IRQ_ENTER: begin
        irq_ack_c    = 1'b1;
        pc_write_c   = 1'b1;
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        irq_pend_d   = 1'b0;
        state_d      = RUN;
      end

      default: state_d = RUN;
    endcase
  end

  // Reset forces every pipeline control low immediately, independent of the clock.
  assign pc_write    = reset & pc_write_c;
  assign ifid_write  = reset & ifid_write_c;
  assign ifid_flush  = reset & ifid_flush_c;
  assign idex_flush  = reset & idex_flush_c;
  assign mdu_start   = reset & mdu_start_c;
  assign irq_ack     = reset & irq_ack_c;
  assign mdu_timeout = mdu_timeout_q;
  assign busy        = (state_q != RUN);

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of the controller's rules.
module tb_hazard_sched;

  localparam int unsigned TMO = 40;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       jump;
    logic       mdu;
    logic       memrd;
    logic [4:0] ert;
    logic       br;
    logic       done;
    logic       irq;
  } stim_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic mdu_start;
    logic irq_ack;
    logic mdu_timeout;
    logic busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, id_jump, id_mdu_op, ex_mem_read, ex_branch_taken, mdu_done, irq;
  logic pc_write, ifid_write, ifid_flush, idex_flush, mdu_start, irq_ack, mdu_timeout, busy;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_sched #(.MDU_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .id_mdu_op(id_mdu_op), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mdu_done(mdu_done), .irq(irq),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .mdu_start(mdu_start), .irq_ack(irq_ack),
    .mdu_timeout(mdu_timeout), .busy(busy)
  );

  // Reference model: what the pipeline is doing, not how the controller encodes it.
  bit m_in_mdu     = 0;
  int m_waited     = 0;
  bit m_entering   = 0;
  bit m_pending    = 0;
  bit m_timed_out  = 0;

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit hazard, take_irq, release_now;
    e = '0;
    take_irq = 0;
    if (!s.rst_n) begin
      m_in_mdu = 0; m_waited = 0; m_entering = 0; m_pending = 0; m_timed_out = 0;
      return e;
    end
    e.mdu_timeout = m_timed_out;
    e.busy        = m_in_mdu || m_entering;
    if (m_entering) begin
      e.irq_ack = 1; e.pc_write = 1; e.ifid_flush = 1; e.idex_flush = 1;
      m_entering = 0;
      m_pending  = 0;
    end else if (m_in_mdu) begin
      m_waited++;
      release_now = s.done || (m_waited == TMO);
      if (s.irq) m_pending = 1;
      if (release_now) begin
        e.pc_write = 1; e.ifid_write = 1;
        m_in_mdu = 0;
        if (!s.done) m_timed_out = 1;
      end else begin
        e.idex_flush = 1;
      end
    end else begin
      hazard = s.memrd && s.ert != 0 && (s.ert == s.rs || (s.uses_rt && s.ert == s.rt));
      e.pc_write = 1; e.ifid_write = 1;
      if (s.br) begin
        e.ifid_flush = 1; e.idex_flush = 1;
      end else if (hazard) begin
        e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
      end else if (s.jump) begin
        e.ifid_flush = 1;
      end else if (s.irq || m_pending) begin
        e.pc_write = 0; e.ifid_write = 0;
        take_irq = 1;
        m_entering = 1;
      end else if (s.mdu) begin
        e.mdu_start = 1; e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
        m_in_mdu = 1;
        m_waited = 0;
      end
      if (s.irq && !take_irq) m_pending = 1;
    end
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    @(negedge clk);
    reset = s.rst_n; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses_rt;
    id_jump = s.jump; id_mdu_op = s.mdu; ex_mem_read = s.memrd; ex_rt = s.ert;
    ex_branch_taken = s.br; mdu_done = s.done; irq = s.irq;
    exp_q.push_back(predict(s));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(idle());
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; sample well after the driving edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_write",    pc_write,    e.pc_write);
        chk("ifid_write",  ifid_write,  e.ifid_write);
        chk("ifid_flush",  ifid_flush,  e.ifid_flush);
        chk("idex_flush",  idex_flush,  e.idex_flush);
        chk("mdu_start",   mdu_start,   e.mdu_start);
        chk("irq_ack",     irq_ack,     e.irq_ack);
        chk("mdu_timeout", mdu_timeout, e.mdu_timeout);
        chk("busy",        busy,        e.busy);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 0; id_jump = 0;
    id_mdu_op = 0; ex_mem_read = 0; ex_branch_taken = 0; mdu_done = 0; irq = 0;

    s = idle(); s.rst_n = 0;
    step(s); step(s);
    idle_steps(2);

    // Load-use stall, then no stall when the load targets $zero.
    s = idle(); s.memrd = 1; s.ert = 5'd8; s.rs = 5'd8; step(s);
    idle_steps(1);
    s = idle(); s.memrd = 1; s.ert = 5'd0; s.rs = 5'd0; step(s);
    s = idle(); s.memrd = 1; s.ert = 5'd9; s.rt = 5'd9; s.uses_rt = 1; step(s);

    // Taken branch overrides a simultaneous load-use.
    s = idle(); s.br = 1; s.memrd = 1; s.ert = 5'd8; s.rs = 5'd8; step(s);
    s = idle(); s.jump = 1; step(s);

    // MDU released by done on the tenth wait cycle.
    s = idle(); s.mdu = 1; step(s);
    idle_steps(9);
    s = idle(); s.done = 1; step(s);
    idle_steps(2);

    // MDU timeout after 40 wait cycles, sticky until reset.
    s = idle(); s.mdu = 1; step(s);
    idle_steps(45);
    s = idle(); s.rst_n = 0; step(s);
    idle_steps(2);

    // Interrupt during MDU wait is deferred until one RUN cycle after release.
    s = idle(); s.mdu = 1; step(s);
    idle_steps(2);
    s = idle(); s.irq = 1; step(s);
    idle_steps(2);
    s = idle(); s.done = 1; step(s);
    idle_steps(4);

    // Done coinciding with the timeout counts as done.
    s = idle(); s.mdu = 1; step(s);
    idle_steps(TMO - 1);
    s = idle(); s.done = 1; step(s);
    idle_steps(2);

    // Asynchronous reset dropped mid-wait.
    s = idle(); s.mdu = 1; step(s);
    idle_steps(3);
    s = idle(); s.rst_n = 0; step(s);
    idle_steps(3);

    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst_n   = ($urandom_range(0, 199) != 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.ert     = 5'($urandom_range(0, 3));
      s.uses_rt = 1'($urandom_range(0, 1));
      s.memrd   = ($urandom_range(0, 2) == 0);
      s.br      = ($urandom_range(0, 7) == 0);
      s.jump    = ($urandom_range(0, 7) == 0);
      s.mdu     = ($urandom_range(0, 5) == 0);
      s.irq     = ($urandom_range(0, 15) == 0);
      s.done    = ($urandom_range(0, 11) == 0);
      step(s);
    end

    repeat (3) @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
